// File: rtl/game_score_timer.sv
// Countdown game timer with a saturating hit score, shown on two active-low
// seven-segment digits. Start and hit inputs are synchronized and edge-detected.
module game_score_timer #(
  parameter int CLK_HZ       = 25000000,
  parameter int GAME_SECONDS = 9
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iHit,
  output logic [6:0] time_segment,
  output logic [6:0] score_segment,
  output logic       oGameActive,
  output logic       oGameOver
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [25:0] TICK_MAX   = 26'(CLK_HZ - 1);
  localparam logic [3:0]  START_TIME = 4'(GAME_SECONDS);

  state_t      state, next_state;
  logic [1:0]  start_sync, hit_sync;
  logic        start_prev, hit_prev;
  logic        start_pulse, hit_pulse;
  logic [25:0] tick_cnt;
  logic [3:0]  time_val, score_val;
  logic        tick;
  logic        active_d, over_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // The pulse is registered so it lands three cycles after the input rises.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      start_sync  <= 2'b00;
      hit_sync    <= 2'b00;
      start_prev  <= 1'b0;
      hit_prev    <= 1'b0;
      start_pulse <= 1'b0;
      hit_pulse   <= 1'b0;
    end else begin
      start_sync  <= {start_sync[0], iStart};
      hit_sync    <= {hit_sync[0], iHit};
      start_prev  <= start_sync[1];
      hit_prev    <= hit_sync[1];
      start_pulse <= start_sync[1] & ~start_prev;
      hit_pulse   <= hit_sync[1] & ~hit_prev;
    end
  end

  assign tick = (state == RUN) && (tick_cnt == TICK_MAX);

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, OVER: if (start_pulse) next_state = RUN;
      RUN:        if (!start_pulse && tick && time_val <= 4'd1) next_state = OVER;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    active_d = (state == RUN);
    over_d   = (state == OVER);
  end

  // A start pulse always wins: it begins a game from IDLE/OVER or restarts one in RUN.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      time_val  <= START_TIME;
      score_val <= 4'd0;
      tick_cnt  <= '0;
    end else if (start_pulse) begin
      time_val  <= START_TIME;
      score_val <= 4'd0;
      tick_cnt  <= '0;
    end else if (state == RUN) begin
      tick_cnt <= tick ? '0 : tick_cnt + 26'd1;
      if (tick) time_val <= (time_val > 4'd1) ? time_val - 4'd1 : 4'd0;
      if (hit_pulse && score_val < 4'd9) score_val <= score_val + 4'd1;
    end else begin
      tick_cnt <= '0;
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      time_segment  <= seg_decode(START_TIME);
      score_segment <= 7'h40;
      oGameActive   <= 1'b0;
      oGameOver     <= 1'b0;
    end else begin
      time_segment  <= seg_decode(time_val);
      score_segment <= seg_decode(score_val);
      oGameActive   <= active_d;
      oGameOver     <= over_d;
    end
  end

endmodule

// File: tb/tb_game_score_timer.sv
// Self-checking bench for game_score_timer: directed scenarios plus a random
// run compared cycle by cycle against a behavioural game model.
module tb_game_score_timer;

  localparam int CLK_HZ = 10;
  localparam int GS     = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic       i_hit = 1'b0;
  logic [6:0] time_segment, score_segment;
  logic       o_active, o_over;

  int tests_run = 0;
  int tests_failed = 0;

  game_score_timer #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS)) dut (
    .iVGA_CLK     (clk),
    .iRST         (rst),
    .iStart       (i_start),
    .iHit         (i_hit),
    .time_segment (time_segment),
    .score_segment(score_segment),
    .oGameActive  (o_active),
    .oGameOver    (o_over)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_code(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Game model: 0 idle, 1 running, 2 over; inputs take effect three edges after rising.
  int         m_state, m_time, m_score, m_run_cycles;
  bit         hs[4], hh[4];
  bit         sp, hp;
  logic [6:0] exp_time, exp_score;
  logic       exp_active, exp_over;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_time = GS; m_score = 0; m_run_cycles = 0;
      for (int i = 0; i < 4; i++) begin hs[i] = 0; hh[i] = 0; end
      exp_time = digit_code(GS); exp_score = digit_code(0);
      exp_active = 0; exp_over = 0;
    end else begin
      sp = hs[2] && !hs[3];
      hp = hh[2] && !hh[3];
      for (int i = 3; i > 0; i--) begin hs[i] = hs[i-1]; hh[i] = hh[i-1]; end
      hs[0] = i_start; hh[0] = i_hit;
      exp_time   = digit_code(m_time);
      exp_score  = digit_code(m_score);
      exp_active = (m_state == 1);
      exp_over   = (m_state == 2);
      if (sp) begin
        m_state = 1; m_time = GS; m_score = 0; m_run_cycles = 0;
      end else if (m_state == 1) begin
        if (hp && m_score < 9) m_score++;
        if ((m_run_cycles + 1) % CLK_HZ == 0) begin
          m_time--;
          if (m_time == 0) m_state = 2;
        end
        m_run_cycles++;
      end
    end
  end

  task test_reset();
    @(negedge clk); #2; rst = 1'b1; #1;
    tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL reset_time got %h want %h", time_segment, 7'h10); end
    tests_run++; if (score_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL reset_score got %h want %h", score_segment, 7'h40); end
    tests_run++; if (o_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_active got %b want 0", o_active); end
    tests_run++; if (o_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_over got %b want 0", o_over); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task test_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL idle_time cyc %0d got %h want %h", c, time_segment, 7'h10); end
      tests_run++; if (score_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL idle_score cyc %0d got %h want %h", c, score_segment, 7'h40); end
      tests_run++; if (o_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_active cyc %0d got %b want 0", c, o_active); end
    end
  endtask

  task test_start();
    @(negedge clk); i_start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 4) begin
        tests_run++; if (o_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL start_early got %b want 0", o_active); end
      end
      if (c == 5) begin
        tests_run++; if (o_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_active got %b want 1", o_active); end
      end
      if (c == 14) begin
        tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL start_time9 got %h want %h", time_segment, 7'h10); end
      end
      if (c == 15) begin
        tests_run++; if (time_segment !== 7'h00) begin tests_failed++; $display("[TB] FAIL start_time8 got %h want %h", time_segment, 7'h00); end
      end
    end
    tests_run++; if (time_segment !== 7'h12) begin tests_failed++; $display("[TB] FAIL start_single got %h want %h", time_segment, 7'h12); end
    tests_run++; if (time_segment !== exp_time) begin tests_failed++; $display("[TB] FAIL start_model got %h want %h", time_segment, exp_time); end
    i_start = 1'b0;
  endtask

  task test_restart();
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    repeat (2) @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL restart_time got %h want %h", time_segment, 7'h10); end
    tests_run++; if (score_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL restart_score got %h want %h", score_segment, 7'h40); end
    tests_run++; if (o_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_active got %b want 1", o_active); end
  endtask

  task test_hits();
    for (int i = 0; i < 12; i++) begin
      i_hit = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      i_hit = 1'b0;
      repeat ($urandom_range(2, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    tests_run++; if (score_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL hits_sat got %h want %h", score_segment, 7'h10); end
    tests_run++; if (score_segment !== exp_score) begin tests_failed++; $display("[TB] FAIL hits_model got %h want %h", score_segment, exp_score); end
    repeat (5) @(negedge clk);
    tests_run++; if (score_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL hits_hold got %h want %h", score_segment, 7'h10); end
  endtask

  task test_game_over();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 120 && !seen; c++) begin
      @(negedge clk);
      if (o_over === 1'b1) seen = 1'b1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL over_timeout got 0 want 1"); end
    tests_run++; if (time_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL over_time got %h want %h", time_segment, 7'h40); end
    tests_run++; if (o_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL over_active got %b want 0", o_active); end
    tests_run++; if (o_over !== exp_over) begin tests_failed++; $display("[TB] FAIL over_model got %b want %b", o_over, exp_over); end
  endtask

  task test_final_tick_hit();
    @(negedge clk); i_start = 1'b1;
    for (int c = 1; c <= 108; c++) begin
      @(negedge clk);
      if (c == 2) i_start = 1'b0;
      if (c == 6) begin
        tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL again_time got %h want %h", time_segment, 7'h10); end
        tests_run++; if (score_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL again_score got %h want %h", score_segment, 7'h40); end
        tests_run++; if (o_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL again_active got %b want 1", o_active); end
      end
      if (c == 90) i_hit = 1'b1;
      if (c == 92) i_hit = 1'b0;
      if (c == 94) begin
        tests_run++; if (score_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL final_pre_score got %h want %h", score_segment, 7'h40); end
        tests_run++; if (o_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL final_pre_over got %b want 0", o_over); end
      end
      if (c == 95) begin
        tests_run++; if (score_segment !== 7'h79) begin tests_failed++; $display("[TB] FAIL final_score got %h want %h", score_segment, 7'h79); end
        tests_run++; if (o_over !== 1'b1) begin tests_failed++; $display("[TB] FAIL final_over got %b want 1", o_over); end
        tests_run++; if (time_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL final_time got %h want %h", time_segment, 7'h40); end
      end
      if (c == 98) i_hit = 1'b1;
      if (c == 100) i_hit = 1'b0;
    end
    tests_run++; if (score_segment !== 7'h79) begin tests_failed++; $display("[TB] FAIL over_hit_ignored got %h want %h", score_segment, 7'h79); end
  endtask

  task test_reset_mid_run();
    @(negedge clk); i_start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 2) i_start = 1'b0;
      if (c == 8 || c == 13 || c == 18) i_hit = 1'b1;
      if (c == 10 || c == 15 || c == 20) i_hit = 1'b0;
    end
    tests_run++; if (time_segment !== 7'h19) begin tests_failed++; $display("[TB] FAIL mid_time got %h want %h", time_segment, 7'h19); end
    tests_run++; if (score_segment !== 7'h30) begin tests_failed++; $display("[TB] FAIL mid_score got %h want %h", score_segment, 7'h30); end
    #2; rst = 1'b1; #1;
    tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL abort_time got %h want %h", time_segment, 7'h10); end
    tests_run++; if (score_segment !== 7'h40) begin tests_failed++; $display("[TB] FAIL abort_score got %h want %h", score_segment, 7'h40); end
    tests_run++; if (o_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_active got %b want 0", o_active); end
    tests_run++; if (o_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_over got %b want 0", o_over); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    tests_run++; if (o_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_active got %b want 0", o_active); end
    tests_run++; if (time_segment !== 7'h10) begin tests_failed++; $display("[TB] FAIL post_reset_time got %h want %h", time_segment, 7'h10); end
  endtask

  task test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      tests_run++; if (time_segment !== exp_time) begin tests_failed++; $display("[TB] FAIL rand_time cyc %0d got %h want %h", c, time_segment, exp_time); end
      tests_run++; if (score_segment !== exp_score) begin tests_failed++; $display("[TB] FAIL rand_score cyc %0d got %h want %h", c, score_segment, exp_score); end
      tests_run++; if (o_active !== exp_active) begin tests_failed++; $display("[TB] FAIL rand_active cyc %0d got %b want %b", c, o_active, exp_active); end
      tests_run++; if (o_over !== exp_over) begin tests_failed++; $display("[TB] FAIL rand_over cyc %0d got %b want %b", c, o_over, exp_over); end
      i_start = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 35) i_hit = ~i_hit;
    end
    i_start = 1'b0;
    i_hit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start();
    test_restart();
    test_hits();
    test_game_over();
    test_final_tick_hit();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
